rom_reader: RTL and testbench

Sequential consumer for the byte-addressable input ROM. After `start`, walks ROM addresses upward from 0 and parses the newline-separated rotation records (`L<decimal>` / `R<decimal>`). Each record is emitted as `{dir, magnitude}` on a single-slot valid/ready stream toward the day-01 solver. Stops at the NUL terminator or on a malformed byte.

---
 rtl/rom_reader_pkg.sv | 33 +++
 rtl/rom_reader_dec_accum.sv | 30 +++
 rtl/rom_reader.sv | 187 ++++++++++++++++++
 tb/tb_rom_reader.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_reader_pkg.sv
// ============================================================================
// Module   : rom_reader_pkg
// Purpose  : FSM state encodings and ASCII byte constants for rom_reader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rom_reader_pkg;

    typedef logic [2:0] state_t;

    localparam state_t c_st_idle        = 3'd0;
    localparam state_t c_st_dir         = 3'd1;
    localparam state_t c_st_digit_first = 3'd2;
    localparam state_t c_st_digit       = 3'd3;
    localparam state_t c_st_done        = 3'd4;
    localparam state_t c_st_err         = 3'd5;

    localparam logic [7:0] c_ascii_l   = 8'h4C;
    localparam logic [7:0] c_ascii_r   = 8'h52;
    localparam logic [7:0] c_ascii_0   = 8'h30;
    localparam logic [7:0] c_ascii_9   = 8'h39;
    localparam logic [7:0] c_ascii_lf  = 8'h0A;
    localparam logic [7:0] c_ascii_cr  = 8'h0D;
    localparam logic [7:0] c_ascii_nul = 8'h00;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= c_ascii_0) && (b <= c_ascii_9);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rom_reader_dec_accum.sv
// ============================================================================
// Module   : dec_accum
// Purpose  : Combinational acc*10+digit step with overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dec_accum #(
    parameter int MAG_W = 16
) (
    input  logic [MAG_W-1:0] i_acc,
    input  logic [3:0]       i_digit,
    output logic [MAG_W-1:0] o_acc,
    output logic             o_ovf
);

    // Four spare bits hold 10*(2^MAG_W-1)+9 without loss.
    localparam logic [MAG_W+3:0] c_ten = (MAG_W+4)'(10);

    logic [MAG_W+3:0] w_wide;

    always_comb begin
        w_wide = ({4'b0000, i_acc} * c_ten) + {{MAG_W{1'b0}}, i_digit};
        o_acc  = w_wide[MAG_W-1:0];
        o_ovf  = |w_wide[MAG_W+3:MAG_W];
    end

endmodule

`default_nettype wire

// File: rtl/rom_reader.sv
// ============================================================================
// Module   : rom_reader
// Purpose  : Walks the input ROM from address 0 and streams L/R rotation
//            records. ROM_READER_CR_SKIP_EN lets CRLF line endings parse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_reader
    import rom_reader_pkg::*;
#(
    parameter int N_ADDR_BITS = 16,
    parameter int MAG_W       = 16,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic [N_ADDR_BITS:0]   rom_addr,
    input  logic [7:0]             rom_data,
    input  logic                   rom_valid,
    output logic                   rec_valid,
    input  logic                   rec_ready,
    output logic                   rec_dir,
    output logic [MAG_W-1:0]       rec_mag,
    output logic                   rec_ovf,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [CNT_W-1:0]       rec_count
);

    state_t               state_q,     state_d;
    logic [N_ADDR_BITS:0] rom_addr_q,  rom_addr_d;
    logic                 rec_valid_q, rec_valid_d;
    logic                 rec_dir_q,   rec_dir_d;
    logic [MAG_W-1:0]     rec_mag_q,   rec_mag_d;
    logic                 rec_ovf_q,   rec_ovf_d;
    logic                 done_q,      done_d;
    logic                 error_q,     error_d;
    logic [CNT_W-1:0]     rec_count_q, rec_count_d;
    logic                 dir_q,       dir_d;
    logic [MAG_W-1:0]     acc_q,       acc_d;
    logic                 acc_ovf_q,   acc_ovf_d;

    logic [MAG_W-1:0]     w_acc_next;
    logic                 w_acc_ovf;
    logic                 w_is_digit;
    logic                 w_can_emit;

    dec_accum #(
        .MAG_W (MAG_W)
    ) u_dec_accum (
        .i_acc   (acc_q),
        .i_digit (rom_data[3:0]),
        .o_acc   (w_acc_next),
        .o_ovf   (w_acc_ovf)
    );

    always_comb begin
        w_is_digit  = rom_valid && is_digit(rom_data);
        w_can_emit  = !rec_valid_q || rec_ready;

        state_d     = state_q;
        rom_addr_d  = rom_addr_q;
        rec_valid_d = rec_valid_q && !rec_ready;
        rec_dir_d   = rec_dir_q;
        rec_mag_d   = rec_mag_q;
        rec_ovf_d   = rec_ovf_q;
        done_d      = done_q;
        error_d     = error_q;
        rec_count_d = rec_count_q;
        dir_d       = dir_q;
        acc_d       = acc_q;
        acc_ovf_d   = acc_ovf_q;

        case (state_q)
            c_st_idle, c_st_done, c_st_err: begin
                if (start) begin
                    rom_addr_d  = '0;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    rec_count_d = '0;
                    state_d     = c_st_dir;
                end
            end
            c_st_dir: begin
                if (!rom_valid) begin
                    done_d  = 1'b1;
                    state_d = c_st_done;
                end else if (rom_data == c_ascii_l || rom_data == c_ascii_r) begin
                    dir_d      = (rom_data == c_ascii_r);
                    acc_d      = '0;
                    acc_ovf_d  = 1'b0;
                    rom_addr_d = rom_addr_q + 1'b1;
                    state_d    = c_st_digit_first;
                end else if (rom_data == c_ascii_lf) begin
                    rom_addr_d = rom_addr_q + 1'b1;
                end else begin
                    error_d = 1'b1;
                    state_d = c_st_err;
                end
            end
            c_st_digit_first: begin
                if (w_is_digit) begin
                    acc_d      = w_acc_next;
                    acc_ovf_d  = acc_ovf_q | w_acc_ovf;
                    rom_addr_d = rom_addr_q + 1'b1;
                    state_d    = c_st_digit;
                end else begin
                    error_d = 1'b1;
                    state_d = c_st_err;
                end
            end
            c_st_digit: begin
                if (w_is_digit) begin
                    acc_d      = w_acc_next;
                    acc_ovf_d  = acc_ovf_q | w_acc_ovf;
                    rom_addr_d = rom_addr_q + 1'b1;
                end else if (rom_valid && rom_data == c_ascii_lf) begin
                    // A full output slot stalls the walk on the newline byte.
                    if (w_can_emit) begin
                        rec_valid_d = 1'b1;
                        rec_dir_d   = dir_q;
                        rec_mag_d   = acc_q;
                        rec_ovf_d   = acc_ovf_q;
                        rec_count_d = rec_count_q + 1'b1;
                        rom_addr_d  = rom_addr_q + 1'b1;
                        state_d     = c_st_dir;
                    end
`ifdef ROM_READER_CR_SKIP_EN
                end else if (rom_valid && rom_data == c_ascii_cr) begin
                    rom_addr_d = rom_addr_q + 1'b1;
`endif
                end else begin
                    error_d = 1'b1;
                    state_d = c_st_err;
                end
            end
            default: state_d = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= c_st_idle;
            rom_addr_q  <= '0;
            rec_valid_q <= 1'b0;
            rec_dir_q   <= 1'b0;
            rec_mag_q   <= '0;
            rec_ovf_q   <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            rec_count_q <= '0;
            dir_q       <= 1'b0;
            acc_q       <= '0;
            acc_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            rec_valid_q <= rec_valid_d;
            rec_dir_q   <= rec_dir_d;
            rec_mag_q   <= rec_mag_d;
            rec_ovf_q   <= rec_ovf_d;
            done_q      <= done_d;
            error_q     <= error_d;
            rec_count_q <= rec_count_d;
            dir_q       <= dir_d;
            acc_q       <= acc_d;
            acc_ovf_q   <= acc_ovf_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign rec_valid = rec_valid_q;
    assign rec_dir   = rec_dir_q;
    assign rec_mag   = rec_mag_q;
    assign rec_ovf   = rec_ovf_q;
    assign done      = done_q;
    assign error     = error_q;
    assign rec_count = rec_count_q;
    assign busy      = (state_q == c_st_dir) || (state_q == c_st_digit_first) ||
                       (state_q == c_st_digit);

endmodule

`default_nettype wire

// File: tb/tb_rom_reader.sv
// ============================================================================
// Module   : tb_rom_reader
// Purpose  : Directed self-checking bench for rom_reader (16-bit and 8-bit
//            magnitude instances sharing one ROM image).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rom_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a;
    logic        start_b;
    logic        rec_ready;
    logic [7:0]  mem [0:63];

    logic [16:0] addr_a, addr_b;
    logic [7:0]  data_a, data_b;
    logic        valid_a, valid_b;

    logic        rec_valid_a, rec_dir_a, rec_ovf_a, busy_a, done_a, error_a;
    logic [15:0] rec_mag_a, cnt_a;
    logic        rec_valid_b, rec_dir_b, rec_ovf_b, busy_b, done_b, error_b;
    logic [7:0]  rec_mag_b;
    logic [15:0] cnt_b;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_xfer   = 0;
    logic        xfer_dir [0:31];
    logic [15:0] xfer_mag [0:31];
    int          base;

    always #5 clk = ~clk;

    rom_reader u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_a),
        .rom_addr  (addr_a),
        .rom_data  (data_a),
        .rom_valid (valid_a),
        .rec_valid (rec_valid_a),
        .rec_ready (rec_ready),
        .rec_dir   (rec_dir_a),
        .rec_mag   (rec_mag_a),
        .rec_ovf   (rec_ovf_a),
        .busy      (busy_a),
        .done      (done_a),
        .error     (error_a),
        .rec_count (cnt_a)
    );

    rom_reader #(.MAG_W(8)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_b),
        .rom_addr  (addr_b),
        .rom_data  (data_b),
        .rom_valid (valid_b),
        .rec_valid (rec_valid_b),
        .rec_ready (rec_ready),
        .rec_dir   (rec_dir_b),
        .rec_mag   (rec_mag_b),
        .rec_ovf   (rec_ovf_b),
        .busy      (busy_b),
        .done      (done_b),
        .error     (error_b),
        .rec_count (cnt_b)
    );

    // ROM model: presents the addressed byte on the falling edge.
    always @(negedge clk) begin
        data_a  <= (addr_a < 17'd64) ? mem[addr_a[5:0]] : 8'h00;
        valid_a <= (addr_a < 17'd64) && (mem[addr_a[5:0]] != 8'h00);
        data_b  <= (addr_b < 17'd64) ? mem[addr_b[5:0]] : 8'h00;
        valid_b <= (addr_b < 17'd64) && (mem[addr_b[5:0]] != 8'h00);
    end

    // Inputs only change just after posedge, so this sees the next transfer.
    always @(negedge clk) begin
        if (rst_n && rec_valid_a && rec_ready) begin
            if (n_xfer < 32) begin
                xfer_dir[n_xfer] = rec_dir_a;
                xfer_mag[n_xfer] = rec_mag_a;
            end
            n_xfer = n_xfer + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic load(input string s);
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        for (int i = 0; i < s.len() && i < 64; i++) mem[i] = s.getc(i);
    endtask

    task automatic start_a_walk();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        start_a   = 1'b0;
        start_b   = 1'b0;
        rec_ready = 1'b1;
        load("");
        run(3);

        check("rst_addr",   32'(addr_a),      32'd0);
        check("rst_valid",  32'(rec_valid_a), 32'd0);
        check("rst_busy",   32'(busy_a),      32'd0);
        check("rst_done",   32'(done_a),      32'd0);
        check("rst_error",  32'(error_a),     32'd0);
        check("rst_count",  32'(cnt_a),       32'd0);
        rst_n = 1'b1;
        tick();

        // Basic two-record walk
        load("L68\nR48\n");
        start_a_walk();
        check("t1_e0_addr", 32'(addr_a), 32'd0);
        check("t1_e0_busy", 32'(busy_a), 32'd1);
        run(4);
        check("t1_r0_valid", 32'(rec_valid_a), 32'd1);
        check("t1_r0_dir",   32'(rec_dir_a),   32'd0);
        check("t1_r0_mag",   32'(rec_mag_a),   32'd68);
        check("t1_r0_cnt",   32'(cnt_a),       32'd1);
        run(4);
        check("t1_r1_valid", 32'(rec_valid_a), 32'd1);
        check("t1_r1_dir",   32'(rec_dir_a),   32'd1);
        check("t1_r1_mag",   32'(rec_mag_a),   32'd48);
        tick();
        check("t1_done",  32'(done_a),      32'd1);
        check("t1_busy",  32'(busy_a),      32'd0);
        check("t1_cnt",   32'(cnt_a),       32'd2);
        check("t1_error", 32'(error_a),     32'd0);
        check("t1_drain", 32'(rec_valid_a), 32'd0);

        // Backpressure: ready low for edges E3..E7
        base = n_xfer;
        load("L1\nR2\n");
        start_a_walk();
        run(2);
        rec_ready = 1'b0;
        tick();
        check("t2_r0_valid", 32'(rec_valid_a), 32'd1);
        check("t2_r0_mag",   32'(rec_mag_a),   32'd1);
        run(3);
        check("t2_stall_addr6", 32'(addr_a), 32'd5);
        tick();
        check("t2_stall_addr7", 32'(addr_a),    32'd5);
        check("t2_stall_mag",   32'(rec_mag_a), 32'd1);
        check("t2_stall_cnt",   32'(cnt_a),     32'd1);
        rec_ready = 1'b1;
        tick();
        check("t2_r1_valid", 32'(rec_valid_a), 32'd1);
        check("t2_r1_dir",   32'(rec_dir_a),   32'd1);
        check("t2_r1_mag",   32'(rec_mag_a),   32'd2);
        check("t2_r1_cnt",   32'(cnt_a),       32'd2);
        tick();
        check("t2_done",   32'(done_a),        32'd1);
        check("t2_nxfer",  32'(n_xfer - base), 32'd2);
        check("t2_x0_dir", 32'(xfer_dir[base]),   32'd0);
        check("t2_x0_mag", 32'(xfer_mag[base]),   32'd1);
        check("t2_x1_dir", 32'(xfer_dir[base+1]), 32'd1);
        check("t2_x1_mag", 32'(xfer_mag[base+1]), 32'd2);

        // Malformed leading byte
        load("X5\n");
        start_a_walk();
        tick();
        check("t3_error", 32'(error_a),     32'd1);
        check("t3_addr",  32'(addr_a),      32'd0);
        check("t3_valid", 32'(rec_valid_a), 32'd0);
        check("t3_busy",  32'(busy_a),      32'd0);
        check("t3_done",  32'(done_a),      32'd0);

        // Direction with no digits
        load("L\n");
        start_a_walk();
        tick();
        check("t3b_e1_error", 32'(error_a), 32'd0);
        tick();
        check("t3b_e2_error", 32'(error_a), 32'd1);
        check("t3b_addr",     32'(addr_a),  32'd1);

        // 8-bit magnitude overflow on the second instance
        load("R300\nL7\n");
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        run(5);
        check("t4_r0_valid", 32'(rec_valid_b), 32'd1);
        check("t4_r0_dir",   32'(rec_dir_b),   32'd1);
        check("t4_r0_mag",   32'(rec_mag_b),   32'd44);
        check("t4_r0_ovf",   32'(rec_ovf_b),   32'd1);
        run(3);
        check("t4_r1_dir", 32'(rec_dir_b), 32'd0);
        check("t4_r1_mag", 32'(rec_mag_b), 32'd7);
        check("t4_r1_ovf", 32'(rec_ovf_b), 32'd0);

        // Blank lines and CRLF endings
        load("\n\nL3\r\nR9\r\n");
        start_a_walk();
        run(5);
`ifdef ROM_READER_CR_SKIP_EN
        check("t5_cr_error", 32'(error_a), 32'd0);
        check("t5_cr_busy",  32'(busy_a),  32'd1);
        tick();
        check("t5_r0_valid", 32'(rec_valid_a), 32'd1);
        check("t5_r0_dir",   32'(rec_dir_a),   32'd0);
        check("t5_r0_mag",   32'(rec_mag_a),   32'd3);
        run(4);
        check("t5_r1_dir", 32'(rec_dir_a), 32'd1);
        check("t5_r1_mag", 32'(rec_mag_a), 32'd9);
        tick();
        check("t5_done",  32'(done_a),  32'd1);
        check("t5_error", 32'(error_a), 32'd0);
`else
        check("t5_cr_error", 32'(error_a), 32'd1);
        check("t5_cr_addr",  32'(addr_a),  32'd4);
        check("t5_cr_busy",  32'(busy_a),  32'd0);
`endif

        // Reset in the middle of a walk with a pending record
        load("L68\nR48\n");
        rec_ready = 1'b0;
        start_a_walk();
        run(6);
        check("t6_pending", 32'(rec_valid_a), 32'd1);
        rst_n = 1'b0;
        tick();
        check("t6_rst_valid", 32'(rec_valid_a), 32'd0);
        check("t6_rst_mag",   32'(rec_mag_a),   32'd0);
        check("t6_rst_dir",   32'(rec_dir_a),   32'd0);
        check("t6_rst_ovf",   32'(rec_ovf_a),   32'd0);
        check("t6_rst_addr",  32'(addr_a),      32'd0);
        check("t6_rst_busy",  32'(busy_a),      32'd0);
        check("t6_rst_cnt",   32'(cnt_a),       32'd0);
        rst_n     = 1'b1;
        rec_ready = 1'b1;
        tick();
        start_a_walk();
        run(4);
        check("t6_r0_dir", 32'(rec_dir_a), 32'd0);
        check("t6_r0_mag", 32'(rec_mag_a), 32'd68);
        run(4);
        check("t6_r1_dir", 32'(rec_dir_a), 32'd1);
        check("t6_r1_mag", 32'(rec_mag_a), 32'd48);
        tick();
        check("t6_done", 32'(done_a), 32'd1);
        check("t6_cnt",  32'(cnt_a),  32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
